// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and constants, also used by the scan-code-to-ASCII stage.
`timescale 1ns/1ps
package ps2_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } ps2_rx_state_t;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam logic        PS2_START      = 1'b0;
    localparam logic        PS2_STOP       = 1'b1;
    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter; idles and resets high.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;

    // The output flips only once the synced line has disagreed with it for FILTER_LEN full cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            dout    <= 1'b1;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q == dout) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN)) begin
                dout  <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: filtered edge detect, 11-bit deserialiser, parity/stop
// check and inter-bit timeout; emits one scan-code byte per valid frame.
`timescale 1ns/1ps
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_code_new,
    output logic [7:0] ps2_code,
    output logic       ps2_err,
    output logic       ps2_busy
);

    localparam int unsigned TIMEOUT_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  LAST_BIT    = 4'(PS2_FRAME_BITS - 2);

    logic          filt_clk;
    logic          filt_data;
    logic          filt_clk_q;
    logic          strobe;
    ps2_rx_state_t state_q;
    logic [8:0]    shreg_q;
    logic [3:0]    bitcnt_q;
    logic [TW-1:0] timer_q;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ps2_clk),
        .dout (filt_clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (ps2_data),
        .dout (filt_data)
    );

    assign strobe   = filt_clk_q & ~filt_clk;
    assign ps2_busy = (state_q == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            filt_clk_q   <= 1'b1;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            timer_q      <= '0;
            ps2_code_new <= 1'b0;
            ps2_code     <= 8'h00;
            ps2_err      <= 1'b0;
        end else begin
            filt_clk_q   <= filt_clk;
            ps2_code_new <= 1'b0;
            ps2_err      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (strobe && filt_data == PS2_START) begin
                        state_q  <= RECV;
                        bitcnt_q <= '0;
                    end
                end
                RECV: begin
                    if (strobe) begin
                        timer_q <= '0;
                        if (bitcnt_q == LAST_BIT) begin
                            // shreg_q holds d0..d7 in [7:0] and parity in [8]
                            state_q  <= IDLE;
                            bitcnt_q <= '0;
                            if ((^shreg_q) && filt_data == PS2_STOP) begin
                                ps2_code     <= shreg_q[7:0];
                                ps2_code_new <= 1'b1;
                            end else begin
                                ps2_err <= 1'b1;
                            end
                        end else begin
                            shreg_q  <= {filt_data, shreg_q[8:1]};
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYC)) begin
                        ps2_err  <= 1'b1;
                        state_q  <= IDLE;
                        bitcnt_q <= '0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: pin-level PS/2 frames at 12.5 kHz against a frame model.
`timescale 1ns/1ps
module tb_ps2_rx_frame;
    import ps2_pkg::*;

    localparam int unsigned CLK_FREQ   = 2_000_000;
    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT_US = 200;
    localparam int          LATENCY    = FILTER_LEN + 4;
    localparam int          HALF_NS    = 40_000;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_code_new;
    logic [7:0] ps2_code;
    logic       ps2_err;
    logic       ps2_busy;

    int tests = 0;
    int fails = 0;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         new_cnt = 0;
    int         err_cnt = 0;
    int         run_bad = 0;
    int         both_bad = 0;
    int         lat_last = 0;
    logic       prev_new = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] code_q[$];
    logic [7:0] exp_code = 8'h00;

    ps2_rx_frame #(
        .CLK_FREQ  (CLK_FREQ),
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_code_new(ps2_code_new),
        .ps2_code    (ps2_code),
        .ps2_err     (ps2_err),
        .ps2_busy    (ps2_busy)
    );

    initial clk = 1'b0;
    always #250 clk = ~clk;

    // Output monitor, sampled 1 ns after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (ps2_code_new) begin
                new_cnt++;
                code_q.push_back(ps2_code);
                lat_last = cyc - fall_cyc;
                if (prev_new) run_bad++;
            end
            if (ps2_err) begin
                err_cnt++;
                if (prev_err) run_bad++;
            end
            if (ps2_code_new && ps2_err) both_bad++;
            prev_new = ps2_code_new;
            prev_err = ps2_err;
        end
    end

    initial begin
        #60_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: a frame is accepted iff data+parity has an odd number of ones and stop is 1.
    function automatic logic frame_ok(input logic [7:0] d, input logic par, input logic stop);
        return ((($countones(d) + int'(par)) % 2) == 1) && (stop == 1'b1);
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // Drives the first nbits of a frame; data changes mid-high, optional clock glitch on glitch_bit.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        @(posedge clk);
        #100;
        for (int i = 0; i < nbits; i++) begin
            #(HALF_NS / 2);
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                #5000;
                ps2_clk = 1'b0;
                #((FILTER_LEN - 1) * 500);
                ps2_clk = 1'b1;
                #(HALF_NS / 2 - 5000 - (FILTER_LEN - 1) * 500);
            end else begin
                #(HALF_NS / 2);
            end
            ps2_clk = 1'b0;
            if (i == 10) fall_cyc = cyc;
            #HALF_NS;
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        #2000;
        tests++;
        if (ps2_code !== 8'h00) begin
            fails++; $display("FAIL reset_code: got %h want 00", ps2_code);
        end
        tests++;
        if ({ps2_code_new, ps2_err, ps2_busy} !== 3'b000) begin
            fails++; $display("FAIL reset_flags: got %b want 000", {ps2_code_new, ps2_err, ps2_busy});
        end
        @(posedge clk);
        #100;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (new_cnt + err_cnt !== 0) begin
            fails++; $display("FAIL reset_release_pulse: got %0d pulses want 0", new_cnt + err_cnt);
        end
    endtask

    task automatic test_good_frame;
        int n0 = new_cnt;
        int e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        exp_code = 8'h1C;
        tests++;
        if (ps2_code !== exp_code) begin
            fails++; $display("FAIL good_code: got %h want %h", ps2_code, exp_code);
        end
        tests++;
        if (new_cnt - n0 !== 1 || err_cnt - e0 !== 0) begin
            fails++; $display("FAIL good_pulses: got new=%0d err=%0d want 1/0", new_cnt - n0, err_cnt - e0);
        end
        tests++;
        if (lat_last !== LATENCY) begin
            fails++; $display("FAIL good_latency: got %0d want %0d", lat_last, LATENCY);
        end
    endtask

    task automatic test_bad_parity;
        int n0 = new_cnt;
        int e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, -1);
        tests++;
        if (new_cnt - n0 !== 0 || err_cnt - e0 !== 1) begin
            fails++; $display("FAIL parity_pulses: got new=%0d err=%0d want 0/1", new_cnt - n0, err_cnt - e0);
        end
        tests++;
        if (ps2_code !== exp_code) begin
            fails++; $display("FAIL parity_code_held: got %h want %h", ps2_code, exp_code);
        end
    endtask

    task automatic test_bad_stop;
        int n0 = new_cnt;
        int e0 = err_cnt;
        send_frame(8'h5A, good_par(8'h5A), 1'b0, 11, -1);
        tests++;
        if (new_cnt - n0 !== 0 || err_cnt - e0 !== 1) begin
            fails++; $display("FAIL stop_pulses: got new=%0d err=%0d want 0/1", new_cnt - n0, err_cnt - e0);
        end
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        exp_code = 8'h5A;
        tests++;
        if (ps2_code !== exp_code) begin
            fails++; $display("FAIL stop_recover_code: got %h want %h", ps2_code, exp_code);
        end
    endtask

    task automatic test_glitch;
        int n0 = new_cnt;
        int e0 = err_cnt;
        send_frame(PS2_BREAK, 1'b1, 1'b1, 11, 3);
        exp_code = PS2_BREAK;
        tests++;
        if (ps2_code !== exp_code || new_cnt - n0 !== 1 || err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL glitch_frame: got code=%h new=%0d err=%0d want %h/1/0",
                     ps2_code, new_cnt - n0, err_cnt - e0, exp_code);
        end
    endtask

    task automatic test_timeout;
        int n0 = new_cnt;
        int e0 = err_cnt;
        send_frame(8'h77, 1'b0, 1'b1, 5, -1);
        tests++;
        if (ps2_busy !== 1'b1) begin
            fails++; $display("FAIL timeout_busy_mid: got %b want 1", ps2_busy);
        end
        #(250_000);
        tests++;
        if (err_cnt - e0 !== 1 || new_cnt - n0 !== 0) begin
            fails++; $display("FAIL timeout_pulses: got err=%0d new=%0d want 1/0", err_cnt - e0, new_cnt - n0);
        end
        tests++;
        if (ps2_busy !== 1'b0) begin
            fails++; $display("FAIL timeout_busy_after: got %b want 0", ps2_busy);
        end
        send_frame(8'h29, good_par(8'h29), 1'b1, 11, -1);
        exp_code = 8'h29;
        tests++;
        if (ps2_code !== exp_code) begin
            fails++; $display("FAIL timeout_recover_code: got %h want %h", ps2_code, exp_code);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n0;
        int e0;
        send_frame(8'hAA, 1'b1, 1'b1, 6, -1);
        @(posedge clk);
        #100;
        rst_n = 1'b0;
        #10;
        tests++;
        if ({ps2_code_new, ps2_err, ps2_busy, ps2_code} !== 11'h000) begin
            fails++;
            $display("FAIL async_reset: got new=%b err=%b busy=%b code=%h want all 0",
                     ps2_code_new, ps2_err, ps2_busy, ps2_code);
        end
        #1000;
        rst_n = 1'b1;
        exp_code = 8'h00;
        n0 = new_cnt;
        e0 = err_cnt;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (new_cnt - n0 !== 0 || err_cnt - e0 !== 0) begin
            fails++; $display("FAIL reset_mid_release: got new=%0d err=%0d want 0/0", new_cnt - n0, err_cnt - e0);
        end
        code_q.delete();
        send_frame(PS2_BREAK, 1'b1, 1'b1, 11, -1);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        exp_code = 8'h1C;
        tests++;
        if (code_q.size() !== 2) begin
            fails++; $display("FAIL back_to_back_count: got %0d want 2", code_q.size());
        end else begin
            tests++;
            if (code_q[0] !== PS2_BREAK || code_q[1] !== 8'h1C) begin
                fails++; $display("FAIL back_to_back_codes: got %h %h want f0 1c", code_q[0], code_q[1]);
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            logic       ok;
            int         n0;
            int         e0;
            d    = 8'($urandom);
            par  = good_par(d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 5) != 0);
            ok   = frame_ok(d, par, stop);
            n0   = new_cnt;
            e0   = err_cnt;
            send_frame(d, par, stop, 11, -1);
            if (ok) exp_code = d;
            tests++;
            if (new_cnt - n0 !== int'(ok) || err_cnt - e0 !== int'(!ok) || ps2_code !== exp_code) begin
                fails++;
                $display("FAIL random_%0d: d=%h par=%b stop=%b got new=%0d err=%0d code=%h want %0d/%0d/%h",
                         k, d, par, stop, new_cnt - n0, err_cnt - e0, ps2_code,
                         int'(ok), int'(!ok), exp_code);
            end
        end
    endtask

    task automatic test_pulse_shape;
        tests++;
        if (run_bad !== 0) begin
            fails++; $display("FAIL pulse_width: got %0d multi-cycle pulses want 0", run_bad);
        end
        tests++;
        if (both_bad !== 0) begin
            fails++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", both_bad);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        test_pulse_shape();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
